// File: rtl/aff7seg_scan.sv
// aff7seg_scan: time-multiplexed scan controller for a 4-digit 7-segment display.
// Holds a packed BCD value and presents one digit per slot to the shared decoder
// while driving the matching digit enable. New values arrive via Load, wait in a
// staging register, and are only copied to the displayed shadow register at a
// frame boundary. This keeps a single frame from mixing old and new digits.
module aff7seg_scan #(
    parameter int CLK_DIV         = 50000,
    parameter int GUARD           = 1,
    parameter bit ENABLE_POLARITY = 1'b0
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [15:0] Value,
    input  logic        Load,
    input  logic        BlankZero,
    output logic        Ack,
    output logic [3:0]  Digit,
    output logic [3:0]  DigEn,
    output logic [1:0]  DigIdx
);

    localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PCNT_GUARD = PW'(GUARD);
    localparam logic [3:0]    EN_OFF     = {4{~ENABLE_POLARITY}};

    logic [PW-1:0] pcnt;
    logic [15:0]   staging;
    logic [15:0]   shadow;
    logic          pending;

    logic          tick;
    logic          boundary;
    logic          transfer;
    logic          guard_ok;
    logic [PW-1:0] pcnt_nxt;
    logic [1:0]    idx_nxt;
    logic [15:0]   shadow_nxt;
    logic [3:0]    blank_nxt;
    logic [3:0]    digit_nxt;
    logic [3:0]    digen_nxt;

    // Next-state view of the scan; outputs are registered from these so that
    // Digit, DigIdx and DigEn all line up with the counter they describe.
    always_comb begin
        tick       = (pcnt == PCNT_LAST);
        boundary   = tick && (DigIdx == 2'd3);
        // A Load in the boundary cycle wins: the older staged value is dropped
        // and the transfer is pushed out by one full frame.
        transfer   = boundary && pending && !Load;
        pcnt_nxt   = tick ? '0 : pcnt + 1'b1;
        idx_nxt    = tick ? DigIdx + 2'd1 : DigIdx;
        shadow_nxt = transfer ? staging : shadow;

        blank_nxt    = 4'b0000;
        blank_nxt[1] = BlankZero && (shadow_nxt[15:4]  == 12'h000);
        blank_nxt[2] = BlankZero && (shadow_nxt[15:8]  == 8'h00);
        blank_nxt[3] = BlankZero && (shadow_nxt[15:12] == 4'h0);

        digit_nxt = shadow_nxt[{idx_nxt, 2'b00} +: 4];

        digen_nxt = EN_OFF;
        if (guard_ok && !blank_nxt[idx_nxt]) begin
            digen_nxt[idx_nxt] = ENABLE_POLARITY;
        end
    end

    // With no guard interval every cycle of a slot may drive its enable.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_ok = 1'b1;
        end else begin : g_guard
            assign guard_ok = (pcnt_nxt >= PCNT_GUARD);
        end
    endgenerate

    // Scan counters, value registers and registered outputs.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            pcnt    <= '0;
            DigIdx  <= 2'd0;
            Digit   <= 4'h0;
            DigEn   <= EN_OFF;
            Ack     <= 1'b0;
            shadow  <= 16'h0000;
            staging <= 16'h0000;
            pending <= 1'b0;
        end else begin
            pcnt   <= pcnt_nxt;
            DigIdx <= idx_nxt;
            Digit  <= digit_nxt;
            DigEn  <= digen_nxt;
            Ack    <= transfer;
            shadow <= shadow_nxt;
            if (Load) begin
                staging <= Value;
                pending <= 1'b1;
            end else if (transfer) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aff7seg_scan.sv
// Bench for aff7seg_scan with CLK_DIV=8, GUARD=1, active-low enables.
// The reference tracks elapsed cycles since reset and derives slot, phase,
// blanking and enables from that with plain arithmetic.
module tb_aff7seg_scan;

    localparam int DIV   = 8;
    localparam int GRD   = 1;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic        blank_zero = 1'b0;
    logic        ack;
    logic [3:0]  digit;
    logic [3:0]  digen;
    logic [1:0]  dig_idx;

    int n_assert = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;

    // reference model state
    int          m_t = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_staging = 16'h0000;
    logic        m_pending = 1'b0;
    logic        m_ack = 1'b0;
    logic        m_bz = 1'b0;

    aff7seg_scan #(.CLK_DIV(DIV), .GUARD(GRD), .ENABLE_POLARITY(1'b0)) dut (
        .Clk(clk), .nReset(nreset), .Value(value), .Load(load),
        .BlankZero(blank_zero), .Ack(ack), .Digit(digit), .DigEn(digen),
        .DigIdx(dig_idx)
    );

    always #5 clk = ~clk;

    // One clock: advance the reference with the inputs present at the edge,
    // then compare every output 1 time unit after the edge.
    task automatic cycle();
        logic        boundary;
        int          idx;
        int          ph;
        logic [15:0] sh;
        logic        blank;
        logic [3:0]  one;
        logic [3:0]  e_digit;
        logic [3:0]  e_digen;
        @(posedge clk);
        if (!nreset) begin
            m_t = 0; m_shadow = 16'h0; m_staging = 16'h0; m_pending = 1'b0; m_ack = 1'b0;
            m_bz = blank_zero;
        end else begin
            boundary = ((m_t % FRAME) == FRAME - 1);
            m_ack = boundary && m_pending && !load;
            if (m_ack) begin
                m_shadow  = m_staging;
                m_pending = 1'b0;
            end
            if (load) begin
                m_staging = value;
                m_pending = 1'b1;
            end
            m_t  = m_t + 1;
            m_bz = blank_zero;
        end
        #1;
        idx     = (m_t / DIV) % 4;
        ph      = m_t % DIV;
        sh      = m_shadow >> (4 * idx);
        e_digit = sh[3:0];
        blank   = m_bz && (idx > 0) && (sh == 16'h0);
        one     = 4'b0001;
        e_digen = (ph >= GRD && !blank) ? ~(one << idx) : 4'hF;
        if (ack === 1'b1) ack_cnt++;

        n_assert++;
        assert (ack === m_ack) else begin
            n_fail++; $error("FAIL ack t=%0d got %b exp %b", m_t, ack, m_ack);
        end
        n_assert++;
        assert (dig_idx === 2'(idx)) else begin
            n_fail++; $error("FAIL dig_idx t=%0d got %0d exp %0d", m_t, dig_idx, idx);
        end
        n_assert++;
        assert (digit === e_digit) else begin
            n_fail++; $error("FAIL digit t=%0d got %h exp %h", m_t, digit, e_digit);
        end
        n_assert++;
        assert (digen === e_digen) else begin
            n_fail++; $error("FAIL digen t=%0d got %b exp %b", m_t, digen, e_digen);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Run until the reference reaches the given cycle-within-frame, bounded.
    task automatic run_to_phase(input int ph);
        for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != ph; i++) cycle();
        n_assert++;
        assert ((m_t % FRAME) == ph) else begin
            n_fail++; $error("FAIL phase_wait got %0d exp %0d", m_t % FRAME, ph);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        cycle();
        load  = 1'b0;
    endtask

    task automatic check_acks(input string tag, input int exp);
        n_assert++;
        assert (ack_cnt == exp) else begin
            n_fail++; $error("FAIL %s ack_count got %0d exp %0d", tag, ack_cnt, exp);
        end
    endtask

    initial begin
        // reset values, with a Load held during reset that must be ignored
        nreset = 1'b0; value = 16'hBEEF; load = 1'b1;
        run(3);
        load = 1'b0;
        nreset = 1'b1;
        run(2 * FRAME);

        // load mid slot 1, transfer at the boundary
        run_to_phase(12);
        ack_cnt = 0;
        do_load(16'h1234);
        run(18);
        check_acks("load_before_boundary", 0);
        run(FRAME);
        check_acks("load_1234", 1);

        // back-to-back loads in one frame: latest wins, one Ack
        run_to_phase(2);
        ack_cnt = 0;
        do_load(16'h1111);
        cycle();
        do_load(16'h2222);
        run(FRAME + 4);
        check_acks("back_to_back", 1);
        n_assert++;
        assert (digit === 4'h2) else begin
            n_fail++; $error("FAIL back_to_back digit got %h exp %h", digit, 4'h2);
        end

        // load in the boundary cycle: transfer one frame later
        run_to_phase(FRAME - 1);
        ack_cnt = 0;
        do_load(16'h5678);
        run(2);
        check_acks("boundary_load_early", 0);
        run(30);
        check_acks("boundary_load_late", 1);
        run(FRAME);

        // leading-zero blanking
        blank_zero = 1'b1;
        do_load(16'h0070);
        run(2 * FRAME);
        do_load(16'h0000);
        run(2 * FRAME);
        do_load(16'h0A05);
        run(2 * FRAME);
        blank_zero = 1'b0;
        run(FRAME);

        // reset mid slot 2 with a pending value
        run_to_phase(20);
        do_load(16'hABCD);
        ack_cnt = 0;
        nreset = 1'b0;
        cycle();
        nreset = 1'b1;
        run(2 * FRAME);
        check_acks("reset_pending", 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            value      = 16'($urandom);
            load       = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) blank_zero = ~blank_zero;
            nreset     = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            cycle();
        end
        load = 1'b0; nreset = 1'b1;
        run(FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
